// File: rtl/mem_wb_ctrl_if.sv
// Purpose: bundles the op, data-bus and register-file-write signals of mem_wb_ctrl.
// Latency: none, wiring only.
// Backpressure: op_ready stalls upstream; bus_req_ready stalls the request.
interface mem_wb_ctrl_if;
  // execute-stage op
  logic        op_valid;
  logic        op_ready;
  logic        op_load;
  logic        op_store;
  logic [2:0]  op_mem;
  logic [63:0] op_addr;
  logic [63:0] op_wdata;
  logic [63:0] op_exe_data;
  logic [4:0]  op_rd;
  logic        op_rd_wen;
  // data bus
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [63:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic [1:0]  bus_req_size;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_data;
  // register-file write port and status
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        busy;
  logic        err;

  // controller side
  modport master (
    input  op_valid, op_load, op_store, op_mem, op_addr, op_wdata, op_exe_data,
           op_rd, op_rd_wen, bus_req_ready, bus_resp_valid, bus_resp_data,
    output op_ready, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
           bus_req_size, rf_wen, rf_waddr, rf_wdata, busy, err
  );

  // environment side (execute stage, memory, register file)
  modport slave (
    output op_valid, op_load, op_store, op_mem, op_addr, op_wdata, op_exe_data,
           op_rd, op_rd_wen, bus_req_ready, bus_resp_valid, bus_resp_data,
    input  op_ready, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
           bus_req_size, rf_wen, rf_waddr, rf_wdata, busy, err
  );
endinterface

// File: rtl/mem_wb_ctrl.sv
// Purpose: sequences one op at a time: ALU writeback or load/store on the data bus; optional MEM_TIMEOUT_EN abort.
// Latency: ALU write 1 cycle after accept; load write 3 cycles minimum; store back to IDLE in 3.
// Backpressure: op_ready low outside IDLE; request payload held while bus_req_ready is low.
module mem_wb_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_ctrl_if.master io
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t      state;
  logic [2:0]  mem_q;
  logic [4:0]  rd_q;
  logic        rd_wen_q;
  logic        store_q;
  logic        to_hit;

  // size code follows the access width: byte, half, word, double
  function automatic logic [1:0] mem_size(input logic [2:0] m);
    case (m)
      3'b001, 3'b100: return 2'd0;
      3'b010, 3'b101: return 2'd1;
      3'b011, 3'b110: return 2'd2;
      default:        return 2'd3;
    endcase
  endfunction

  // load data extension; code 000 carries no defined width so it yields zero
  function automatic logic [63:0] load_ext(input logic [2:0] m, input logic [63:0] d);
    case (m)
      3'b001:  return {{56{d[7]}},  d[7:0]};
      3'b010:  return {{48{d[15]}}, d[15:0]};
      3'b011:  return {{32{d[31]}}, d[31:0]};
      3'b100:  return {56'd0, d[7:0]};
      3'b101:  return {48'd0, d[15:0]};
      3'b110:  return {32'd0, d[31:0]};
      3'b111:  return d;
      default: return 64'd0;
    endcase
  endfunction

  // ready is gated by reset so upstream never hands over an op during reset
  assign io.op_ready = (state == IDLE) && !rst;
  assign io.busy     = (state != IDLE) && !rst;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       err_q;

  // counter is cleared while idle, so it starts at zero on entry to REQ
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= 8'd0;
    end else if (state == IDLE) begin
      to_cnt <= 8'd0;
    end else if (state == REQ || state == WAIT) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // abort fires on the cycle the count would reach TIMEOUT
  assign to_hit = (state == REQ || state == WAIT) && (to_cnt == 8'(TIMEOUT - 1));

  // one-cycle error pulse in the cycle after the abort decision
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= to_hit;
  end

  assign io.err = err_q;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign to_hit = 1'b0;
  assign io.err = 1'b0;
`endif

  // main sequencing FSM; all bus and RF outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      mem_q            <= 3'd0;
      rd_q             <= 5'd0;
      rd_wen_q         <= 1'b0;
      store_q          <= 1'b0;
      io.bus_req_valid <= 1'b0;
      io.bus_req_we    <= 1'b0;
      io.bus_req_addr  <= 64'd0;
      io.bus_req_wdata <= 64'd0;
      io.bus_req_size  <= 2'd0;
      io.rf_wen        <= 1'b0;
      io.rf_waddr      <= 5'd0;
      io.rf_wdata      <= 64'd0;
    end else begin
      io.rf_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (io.op_valid) begin
            if (io.op_load || io.op_store) begin
              // load wins when both kinds are flagged
              mem_q            <= io.op_mem;
              rd_q             <= io.op_rd;
              rd_wen_q         <= io.op_rd_wen;
              store_q          <= io.op_store && !io.op_load;
              io.bus_req_valid <= 1'b1;
              io.bus_req_we    <= io.op_store && !io.op_load;
              io.bus_req_addr  <= io.op_addr;
              io.bus_req_wdata <= io.op_wdata;
              io.bus_req_size  <= mem_size(io.op_mem);
              state            <= REQ;
            end else if (io.op_rd_wen && io.op_rd != 5'd0) begin
              io.rf_wen   <= 1'b1;
              io.rf_waddr <= io.op_rd;
              io.rf_wdata <= io.op_exe_data;
            end
          end
        end
        REQ: begin
          // responses are ignored here, including one coincident with acceptance
          if (to_hit) begin
            io.bus_req_valid <= 1'b0;
            state            <= IDLE;
          end else if (io.bus_req_ready) begin
            io.bus_req_valid <= 1'b0;
            state            <= WAIT;
          end
        end
        WAIT: begin
          if (to_hit) begin
            state <= IDLE;
          end else if (io.bus_resp_valid) begin
            if (store_q) begin
              state <= IDLE;
            end else begin
              if (rd_wen_q && rd_q != 5'd0) begin
                io.rf_wen   <= 1'b1;
                io.rf_waddr <= rd_q;
                io.rf_wdata <= load_ext(mem_q, io.bus_resp_data);
              end
              state <= WB;
            end
          end
        end
        default: begin
          // WB: the write registered on the way in is visible this cycle
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Purpose: scoreboard bench for mem_wb_ctrl with directed and random ops.
// Latency: checks ALU, load and store timing plus the optional timeout.
// Backpressure: drives random bus_req_ready stalls and verifies payload hold.
module tb_mem_wb_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_ctrl_if bus_if ();

  mem_wb_ctrl #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus_if)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } rf_t;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
  } req_t;

  rf_t  exp_rf[$];
  req_t exp_req[$];
  int   checks   = 0;
  int   failures = 0;
  logic stall_prev = 1'b0;
  req_t held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: access width in bytes is 1,2,4 cycling through codes 1..6; 0 and 7 are doubles
  function automatic logic [1:0] m_size(input logic [2:0] c);
    int ci;
    ci = int'(c);
    if (ci == 0 || ci == 7) return 2'd3;
    return 2'((ci - 1) % 3);
  endfunction

  // reference: mask to the access width, then fill upper bits with the sign for codes below 4
  function automatic logic [63:0] m_ext(input logic [2:0] c, input logic [63:0] d);
    int          w;
    logic [63:0] mask;
    logic [63:0] v;
    if (c == 3'd0) return 64'd0;
    if (c == 3'd7) return d;
    w    = 8 << ((int'(c) - 1) % 3);
    mask = (64'd1 << w) - 64'd1;
    v    = d & mask;
    if (c < 3'd4 && d[w-1]) v = v | ~mask;
    return v;
  endfunction

  // monitor: compares RF writes and accepted requests with the scoreboard, checks payload hold
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus_if.rf_wen) begin
        if (exp_rf.size() == 0) begin
          chk("rf_unexpected_wen", 64'(bus_if.rf_waddr), 64'd0);
          if (bus_if.rf_waddr == 5'd0) begin
            checks++;
            failures++;
            $display("FAIL rf_unexpected_wen: got write to x0 expected none");
          end
        end else begin
          rf_t e;
          e = exp_rf.pop_front();
          chk("rf_waddr", 64'(bus_if.rf_waddr), 64'(e.a));
          chk("rf_wdata", bus_if.rf_wdata, e.d);
        end
      end
      if (stall_prev) begin
        chk("hold_valid", 64'(bus_if.bus_req_valid), 64'd1);
        chk("hold_we",    64'(bus_if.bus_req_we),    64'(held.we));
        chk("hold_addr",  bus_if.bus_req_addr,       held.addr);
        chk("hold_wdata", bus_if.bus_req_wdata,      held.wdata);
        chk("hold_size",  64'(bus_if.bus_req_size),  64'(held.size));
      end
      if (bus_if.bus_req_valid && bus_if.bus_req_ready) begin
        if (exp_req.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_unexpected: got request addr %h expected none", bus_if.bus_req_addr);
        end else begin
          req_t r;
          r = exp_req.pop_front();
          chk("req_we",   64'(bus_if.bus_req_we),   64'(r.we));
          chk("req_addr", bus_if.bus_req_addr,      r.addr);
          chk("req_size", 64'(bus_if.bus_req_size), 64'(r.size));
          if (r.we) chk("req_wdata", bus_if.bus_req_wdata, r.wdata);
        end
      end
      stall_prev = bus_if.bus_req_valid && !bus_if.bus_req_ready;
      held = '{bus_if.bus_req_we, bus_if.bus_req_addr, bus_if.bus_req_wdata, bus_if.bus_req_size};
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus_if.op_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) chk("op_ready_timeout", 64'(bus_if.op_ready), 64'd1);
  endtask

  task automatic drive_op(input bit ld, input bit st, input logic [2:0] mem,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exe, input logic [4:0] rd, input bit wen);
    bus_if.op_valid    = 1'b1;
    bus_if.op_load     = ld;
    bus_if.op_store    = st;
    bus_if.op_mem      = mem;
    bus_if.op_addr     = addr;
    bus_if.op_wdata    = wdata;
    bus_if.op_exe_data = exe;
    bus_if.op_rd       = rd;
    bus_if.op_rd_wen   = wen;
  endtask

  task automatic issue(input bit ld, input bit st, input logic [2:0] mem,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exe, input logic [63:0] rdata,
                       input logic [4:0] rd, input bit wen,
                       input int rdy_dly, input int resp_dly, input bit inj);
    req_t r;
    rf_t  w;
    wait_ready();
    drive_op(ld, st, mem, addr, wdata, exe, rd, wen);
    @(posedge clk); #1;
    bus_if.op_valid = 1'b0;
    if (!ld && !st) begin
      if (wen && rd != 5'd0) begin
        w = '{rd, exe};
        exp_rf.push_back(w);
      end
      return;
    end
    r = '{st && !ld, addr, wdata, m_size(mem)};
    exp_req.push_back(r);
    for (int i = 0; i < rdy_dly; i++) begin
      bus_if.bus_resp_valid = inj && (i == 0);
      bus_if.bus_resp_data  = {$urandom(), $urandom()};
      @(posedge clk); #1;
    end
    bus_if.bus_resp_valid = inj && (rdy_dly == 0);
    bus_if.bus_resp_data  = {$urandom(), $urandom()};
    bus_if.bus_req_ready  = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    for (int i = 0; i < resp_dly; i++) begin
      @(posedge clk); #1;
    end
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_data  = rdata;
    @(posedge clk); #1;
    bus_if.bus_resp_valid = 1'b0;
    if (ld && wen && rd != 5'd0) begin
      w = '{rd, m_ext(mem, rdata)};
      exp_rf.push_back(w);
    end
    if (rdy_dly == 0 && resp_dly == 0) begin
      if (ld) begin
        chk("load_t3_op_ready", 64'(bus_if.op_ready), 64'd0);
        chk("load_t3_busy",     64'(bus_if.busy),     64'd1);
        @(posedge clk); #1;
        chk("load_t4_op_ready", 64'(bus_if.op_ready), 64'd1);
      end else begin
        chk("store_t3_op_ready", 64'(bus_if.op_ready), 64'd1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.op_valid       = 1'b0;
    bus_if.op_load        = 1'b0;
    bus_if.op_store       = 1'b0;
    bus_if.op_mem         = 3'd0;
    bus_if.op_addr        = 64'd0;
    bus_if.op_wdata       = 64'd0;
    bus_if.op_exe_data    = 64'd0;
    bus_if.op_rd          = 5'd0;
    bus_if.op_rd_wen      = 1'b0;
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_resp_data  = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(bus_if.bus_req_valid), 64'd0);
    chk("rst_req_we",    64'(bus_if.bus_req_we),    64'd0);
    chk("rst_req_addr",  bus_if.bus_req_addr,       64'd0);
    chk("rst_req_wdata", bus_if.bus_req_wdata,      64'd0);
    chk("rst_req_size",  64'(bus_if.bus_req_size),  64'd0);
    chk("rst_rf_wen",    64'(bus_if.rf_wen),        64'd0);
    chk("rst_rf_waddr",  64'(bus_if.rf_waddr),      64'd0);
    chk("rst_rf_wdata",  bus_if.rf_wdata,           64'd0);
    chk("rst_busy",      64'(bus_if.busy),          64'd0);
    chk("rst_err",       64'(bus_if.err),           64'd0);
    chk("rst_op_ready",  64'(bus_if.op_ready),      64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_op_ready", 64'(bus_if.op_ready), 64'd1);

    // ALU writes, including rd=0 suppression and back-to-back issue
    issue(0, 0, 3'd0, 64'd0, 64'd0, 64'h1234, 64'd0, 5'd5, 1, 0, 0, 0);
    issue(0, 0, 3'd0, 64'd0, 64'd0, 64'h1234, 64'd0, 5'd0, 1, 0, 0, 0);
    issue(0, 0, 3'd0, 64'd0, 64'd0, 64'hAAAA, 64'd0, 5'd6, 1, 0, 0, 0);
    issue(0, 0, 3'd0, 64'd0, 64'd0, 64'hBBBB, 64'd0, 5'd7, 0, 0, 0, 0);
    issue(0, 0, 3'd0, 64'd0, 64'd0, 64'hCCCC, 64'd0, 5'd31, 1, 0, 0, 0);

    // lb / lbu of 0x80, lw under backpressure with a stray response, sd
    issue(1, 0, 3'b001, 64'h1000, 64'd0, 64'd0, 64'h80, 5'd3, 1, 0, 0, 0);
    issue(1, 0, 3'b100, 64'h1001, 64'd0, 64'd0, 64'h80, 5'd4, 1, 0, 0, 0);
    issue(1, 0, 3'b011, 64'h2000, 64'd0, 64'd0, 64'h0000_0000_8000_0001, 5'd8, 1, 4, 1, 1);
    issue(0, 1, 3'b111, 64'h3000, 64'hDEAD_BEEF, 64'd0, 64'h5555, 5'd9, 1, 0, 0, 0);
    issue(1, 1, 3'b010, 64'h4000, 64'd0, 64'd0, 64'h8001, 5'd10, 1, 1, 2, 0);
    issue(1, 0, 3'b000, 64'h5000, 64'd0, 64'd0, 64'hFFFF, 5'd11, 1, 0, 0, 0);

    // reset while waiting for a response: no write, late response ignored
    wait_ready();
    drive_op(1, 0, 3'b111, 64'h6000, 64'd0, 64'd0, 5'd12, 1);
    @(posedge clk); #1;
    bus_if.op_valid = 1'b0;
    exp_req.push_back('{1'b0, 64'h6000, 64'd0, 2'd3});
    bus_if.bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_req_ready = 1'b0;
    @(posedge clk); #1;
    chk("wait_busy", 64'(bus_if.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rf_wen",    64'(bus_if.rf_wen),        64'd0);
    chk("midrst_req_valid", 64'(bus_if.bus_req_valid), 64'd0);
    chk("midrst_op_ready",  64'(bus_if.op_ready),      64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_after_busy",     64'(bus_if.busy),     64'd0);
    chk("midrst_after_op_ready", 64'(bus_if.op_ready), 64'd1);
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_data  = 64'h1111;
    @(posedge clk); #1;
    bus_if.bus_resp_valid = 1'b0;
    @(posedge clk); #1;
    chk("late_resp_rf_wen", 64'(bus_if.rf_wen), 64'd0);

    // randomized mix
    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic [63:0] rdata;
      kind  = int'($urandom_range(0, 3));
      rdata = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) rdata[31:0] = $urandom_range(0, 255);
      issue(kind == 1 || kind == 3, kind == 2 || kind == 3,
            3'($urandom_range(0, 7)), {$urandom(), $urandom()}, {$urandom(), $urandom()},
            {$urandom(), $urandom()}, rdata, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

`ifdef MEM_TIMEOUT_EN
    // timeout with no response: err pulses once at T+9, back in IDLE, no write
    wait_ready();
    drive_op(1, 0, 3'b011, 64'h7000, 64'd0, 64'd0, 5'd13, 1);
    @(posedge clk); #1;
    bus_if.op_valid = 1'b0;
    exp_req.push_back('{1'b0, 64'h7000, 64'd0, 2'd2});
    bus_if.bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_req_ready = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      chk($sformatf("timeout_err_t%0d", k), 64'(bus_if.err), (k == 9) ? 64'd1 : 64'd0);
      if (k == 9) chk("timeout_busy", 64'(bus_if.busy), 64'd0);
      @(posedge clk); #1;
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rf_queue_empty",  64'(exp_rf.size()),  64'd0);
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
